// File: rtl/rgb_cmp_pwm_driver.sv
// ============================================================================
// Module   : rgb_cmp_pwm_driver
// Brief    : Registered unsigned compare of two operands shown on an RGB LED,
//            PWM-dimmed with optional blink that restarts on a result change.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rgb_cmp_pwm_driver #(
    parameter int WIDTH         = 4,
    parameter int PWM_BITS      = 8,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                load,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                blink_en,
    output logic                rgb_led_r,
    output logic                rgb_led_g,
    output logic                rgb_led_b
);

    localparam int BC_W = $clog2(BLINK_PERIODS) + 1;
    localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_PERIODS - 1);

    typedef enum logic [1:0] {
        STEADY    = 2'd0,
        BLINK_ON  = 2'd1,
        BLINK_OFF = 2'd2
    } state_t;

    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BC_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic [2:0]          flags_q, flags_d;   // {gt, lt, eq}
    logic [2:0]          led_q, led_d;       // {r, g, b}
    state_t              state_q, state_d;

    logic wrap;
    logic pwm_on;
    logic gate;
    logic result_change;

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        duty_d      = duty_q;
        flags_d     = flags_q;
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        led_d       = 3'b000;

        wrap   = &pwm_cnt_q;
        pwm_on = (pwm_cnt_q < duty_q);
        gate   = (state_q != BLINK_OFF);

        if (load) begin
            a_d = a;
            b_d = b;
        end

        // Flags follow the captured operands one cycle later; those only move on load.
        if (a_q > b_q) begin
            flags_d = 3'b100;
        end else if (a_q < b_q) begin
            flags_d = 3'b010;
        end else begin
            flags_d = 3'b001;
        end
        result_change = (flags_d != flags_q);

        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        if (wrap) begin
            duty_d = duty;
        end

        if (!blink_en) begin
            state_d     = STEADY;
            blink_cnt_d = '0;
        end else if (result_change) begin
            // A new result restarts the blink visibly lit, overriding any toggle.
            state_d     = BLINK_ON;
            blink_cnt_d = '0;
        end else if (wrap) begin
            case (state_q)
                STEADY: begin
                    state_d     = BLINK_ON;
                    blink_cnt_d = '0;
                end
                BLINK_ON, BLINK_OFF: begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        state_d     = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BC_W'(1);
                    end
                end
                default: begin
                    state_d     = STEADY;
                    blink_cnt_d = '0;
                end
            endcase
        end

        led_d = flags_q & {3{pwm_on & gate}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            duty_q      <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            flags_q     <= 3'b001;
            state_q     <= STEADY;
            led_q       <= 3'b000;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            duty_q      <= duty_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            flags_q     <= flags_d;
            state_q     <= state_d;
            led_q       <= led_d;
        end
    end

    assign rgb_led_r = led_q[2];
    assign rgb_led_g = led_q[1];
    assign rgb_led_b = led_q[0];

endmodule

`default_nettype wire

// File: tb/tb_rgb_cmp_pwm_driver.sv
// ============================================================================
// Module   : tb_rgb_cmp_pwm_driver
// Brief    : Directed bench for rgb_cmp_pwm_driver (WIDTH=4, PWM_BITS=4, BLINK_PERIODS=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rgb_cmp_pwm_driver;

    localparam logic [2:0] C_R   = 3'b100;
    localparam logic [2:0] C_G   = 3'b010;
    localparam logic [2:0] C_B   = 3'b001;
    localparam logic [2:0] C_OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a, b;
    logic       load;
    logic [3:0] duty;
    logic       blink_en;
    logic       rgb_led_r, rgb_led_g, rgb_led_b;

    int checks   = 0;
    int failures = 0;
    int k        = 0;          // edges since the last reset edge
    logic [2:0] ef;            // colour the registered flags select
    int         exp_duty;      // duty value the PWM is currently using
    logic       gate;          // 0 while the blink is in its dark half

    rgb_cmp_pwm_driver #(
        .WIDTH        (4),
        .PWM_BITS     (4),
        .BLINK_PERIODS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .load     (load),
        .duty     (duty),
        .blink_en (blink_en),
        .rgb_led_r(rgb_led_r),
        .rgb_led_g(rgb_led_g),
        .rgb_led_b(rgb_led_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, expv);
        end
    endtask

    // Output at edge k reflects the counter value k-1 and the duty/state before that edge.
    task automatic tick_chk(input string tag);
        logic [2:0] expv;
        @(posedge clk);
        #1;
        k++;
        expv = ef & {3{(((k - 1) % 16) < exp_duty) && gate}};
        chk(tag, {rgb_led_r, rgb_led_g, rgb_led_b}, expv);
        if (k % 16 == 0) exp_duty = int'(duty);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick_chk(tag);
    endtask

    task automatic do_load(input logic [3:0] aa, input logic [3:0] bb,
                           input logic [2:0] newef, input string tag);
        a    = aa;
        b    = bb;
        load = 1'b1;
        tick_chk(tag);
        load = 1'b0;
        tick_chk(tag);
        ef = newef;
    endtask

    initial begin
        rst      = 1'b1;
        a        = 4'd0;
        b        = 4'd0;
        load     = 1'b0;
        duty     = 4'd0;
        blink_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {rgb_led_r, rgb_led_g, rgb_led_b}, C_OFF);

        rst      = 1'b0;
        duty     = 4'd8;
        k        = 0;
        ef       = C_B;
        exp_duty = 0;
        gate     = 1'b1;
        run(32, "idle_blue");

        do_load(4'd9, 4'd3, C_R, "load_gt");
        run(30, "red_d8");
        do_load(4'd3, 4'd9, C_G, "load_lt");
        run(14, "green_d8");
        do_load(4'd5, 4'd5, C_B, "load_eq");
        run(14, "blue_d8");
        do_load(4'd15, 4'd0, C_R, "load_max");
        run(14, "red_max");

        duty = 4'd0;
        run(16, "duty0_pending");
        run(8, "duty0");
        duty = 4'd15;
        run(8, "duty0_tail");
        run(6, "duty15");
        duty = 4'd4;
        run(10, "duty_midchange");
        duty = 4'd15;
        run(16, "duty4");

        blink_en = 1'b1;
        run(16, "blink_armed");
        run(32, "blink_on1");
        gate = 1'b0;
        run(32, "blink_off1");
        gate = 1'b1;
        run(32, "blink_on2");
        gate = 1'b0;
        run(14, "blink_off2");

        a    = 4'd3;
        b    = 4'd9;
        load = 1'b1;
        tick_chk("dark_load");
        load = 1'b0;
        tick_chk("dark_load");
        ef   = C_G;
        gate = 1'b1;
        run(32, "restart_on");
        gate = 1'b0;
        run(32, "restart_off");
        gate = 1'b1;
        run(4, "green_on");

        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_midblink", {rgb_led_r, rgb_led_g, rgb_led_b}, C_OFF);
        rst      = 1'b0;
        k        = 0;
        ef       = C_B;
        exp_duty = 0;
        gate     = 1'b1;
        run(32, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
